// File: rtl/ahb_apb_bridge_core_if.sv
// Bus bundle between an AHB master / APB slave environment and the bridge core.
//
// Handshake: an AHB address phase is a transfer when htrans is NONSEQ (10) or
// SEQ (11); it is taken on a rising hclk edge where hready_in is high.  The
// bridge lowers hr_readyout to stall, and while it is low the master keeps
// haddr, htrans, hwrite and the pending hwdata stable.  On the APB side every
// transfer is one setup cycle (psel != 0, penable = 0) followed by one enable
// cycle (penable = 1); prdata is returned through hr_data in the enable cycle.
interface ahb_apb_bridge_core_if;
    // AHB side, into the bridge
    logic        hwrite;
    logic        hready_in;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] haddr;
    // APB side, into the bridge
    logic [31:0] prdata;
    // Bridge outputs
    logic        penable;
    logic        pwrite;
    logic        hr_readyout;
    logic [2:0]  psel;
    logic [1:0]  hresp;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] hr_data;

    // Bridge view
    modport slave (
        input  hwrite, hready_in, htrans, hwdata, haddr, prdata,
        output penable, pwrite, hr_readyout, psel, hresp, paddr, pwdata, hr_data
    );

    // Environment view (AHB master plus APB slave)
    modport master (
        output hwrite, hready_in, htrans, hwdata, haddr, prdata,
        input  penable, pwrite, hr_readyout, psel, hresp, paddr, pwdata, hr_data
    );
endinterface

// File: rtl/ahb_apb_bridge_core.sv
// AHB-to-APB bridge core: AHB slave front end (address/data/direction
// pipeline, slave decode, transfer qualifier) and an APB controller FSM that
// turns each AHB transfer into an APB setup + enable pair.
module ahb_apb_bridge_core (
    input  logic                        hclk,
    input  logic                        hresetn,   // active-high synchronous reset
    ahb_apb_bridge_core_if.slave        bus,
    output logic [2:0]                  o_dbg_state,
    output logic                        o_dbg_hwrite_reg1,
    output logic [31:0]                 o_dbg_hwdata2
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_t;

    state_t      r_state;

    logic [31:0] r_haddr1;
    logic [31:0] r_haddr2;
    logic [31:0] r_hwdata1;
    logic [31:0] r_hwdata2;
    logic        r_hwrite_reg;
    logic        r_hwrite_reg1;

    logic        r_penable;
    logic        r_pwrite;
    logic        r_hr_readyout;
    logic [2:0]  r_psel;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;

    logic        w_valid;
    logic        w_in_range;
    logic [2:0]  w_temp_sel;

    // Address decode and transfer qualifier; three 64 MB slave windows from 0x8000_0000
    always_comb begin
        w_in_range = (bus.haddr >= 32'h8000_0000) && (bus.haddr < 32'h8C00_0000);
        w_valid    = bus.hready_in && bus.htrans[1] && w_in_range;
        w_temp_sel = 3'b000;
        case (bus.haddr[31:26])
            6'b100000: w_temp_sel = 3'b001;
            6'b100001: w_temp_sel = 3'b010;
            6'b100010: w_temp_sel = 3'b100;
            default:   w_temp_sel = 3'b000;
        endcase
    end

    // Two-deep pipeline of address, write data and direction
    always_ff @(posedge hclk) begin
        if (hresetn) begin
            r_haddr1      <= '0;
            r_haddr2      <= '0;
            r_hwdata1     <= '0;
            r_hwdata2     <= '0;
            r_hwrite_reg  <= 1'b0;
            r_hwrite_reg1 <= 1'b0;
        end else begin
            r_haddr1      <= bus.haddr;
            r_haddr2      <= r_haddr1;
            r_hwdata1     <= bus.hwdata;
            r_hwdata2     <= r_hwdata1;
            r_hwrite_reg  <= bus.hwrite;
            r_hwrite_reg1 <= r_hwrite_reg;
        end
    end

    // APB controller: next state and the registered APB/ready outputs it loads on leaving each state
    always_ff @(posedge hclk) begin
        if (hresetn) begin
            r_state       <= ST_IDLE;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_psel        <= 3'b000;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_hr_readyout <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                    if (w_valid && !bus.hwrite) begin
                        // Read goes straight to setup with the live address
                        r_state       <= ST_READ;
                        r_paddr       <= bus.haddr;
                        r_pwrite      <= 1'b0;
                        r_psel        <= w_temp_sel;
                        r_penable     <= 1'b0;
                        r_hr_readyout <= 1'b0;
                    end else begin
                        // Write waits one cycle for its data phase
                        r_state       <= w_valid ? ST_WWAIT : ST_IDLE;
                        r_psel        <= 3'b000;
                        r_penable     <= 1'b0;
                        r_hr_readyout <= 1'b1;
                    end
                end
                ST_WWAIT: begin
                    r_state       <= w_valid ? ST_WRITEP : ST_WRITE;
                    r_paddr       <= r_haddr1;
                    r_pwdata      <= bus.hwdata;
                    r_pwrite      <= 1'b1;
                    r_psel        <= w_temp_sel;
                    r_penable     <= 1'b0;
                    r_hr_readyout <= 1'b0;
                end
                ST_READ: begin
                    r_state       <= ST_RENABLE;
                    r_penable     <= 1'b1;
                    r_hr_readyout <= 1'b1;
                end
                ST_WRITE: begin
                    r_state       <= w_valid ? ST_WENABLEP : ST_WENABLE;
                    r_penable     <= 1'b1;
                    r_hr_readyout <= 1'b1;
                end
                ST_WRITEP: begin
                    r_state       <= ST_WENABLEP;
                    r_penable     <= 1'b1;
                    r_hr_readyout <= 1'b1;
                end
                ST_WENABLEP: begin
                    // Pipelined write: the pending transfer is two address phases back
                    if (!r_hwrite_reg) begin
                        r_state <= ST_READ;
                    end else begin
                        r_state <= w_valid ? ST_WRITEP : ST_WRITE;
                    end
                    r_paddr       <= r_haddr2;
                    r_pwdata      <= bus.hwdata;
                    r_pwrite      <= bus.hwrite;
                    r_psel        <= w_temp_sel;
                    r_penable     <= 1'b0;
                    r_hr_readyout <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.penable     = r_penable;
    assign bus.pwrite      = r_pwrite;
    assign bus.hr_readyout = r_hr_readyout;
    assign bus.psel        = r_psel;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
    assign bus.hresp       = 2'b00;
    assign bus.hr_data     = bus.prdata;

    assign o_dbg_state       = r_state;
    assign o_dbg_hwrite_reg1 = r_hwrite_reg1;
    assign o_dbg_hwdata2     = r_hwdata2;

endmodule

// File: tb/tb_ahb_apb_bridge_core.sv
// Testbench for ahb_apb_bridge_core: AHB master driver, APB slave/monitor and
// a transaction-level model (expected APB transfers in acceptance order).
module tb_ahb_apb_bridge_core;

    logic        hclk;
    logic        hresetn;
    logic [2:0]  dbg_state;
    logic        dbg_hwrite_reg1;
    logic [31:0] dbg_hwdata2;

    ahb_apb_bridge_core_if bus ();

    ahb_apb_bridge_core dut (
        .hclk              (hclk),
        .hresetn           (hresetn),
        .bus               (bus.slave),
        .o_dbg_state       (dbg_state),
        .o_dbg_hwrite_reg1 (dbg_hwrite_reg1),
        .o_dbg_hwdata2     (dbg_hwdata2)
    );

    // Single-slave system: the AHB ready seen by the bridge is its own readyout
    assign bus.hready_in = bus.hr_readyout;

    // ---------------- clock / reset ----------------
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    // {wr, addr, wdata, rdata}
    logic [96:0] exp_q[$];
    logic [96:0] cur;
    logic        in_setup = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Slave window index from the address map, as a one-hot select
    function automatic logic [2:0] sel_of(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - 32'h8000_0000) / 32'h0400_0000;
        return 3'b001 << idx;
    endfunction

    // APB monitor and slave: every transfer must be setup then enable, in AHB order
    always @(negedge hclk) begin
        if (hresetn) begin
            in_setup = 1'b0;
        end else begin
            chk("hresp", 32'(bus.hresp), 32'h0);
            chk("readyout_rule", 32'(bus.hr_readyout),
                32'(!((bus.psel != 3'b000) && !bus.penable)));
            if (in_setup) begin
                chk("en_penable", 32'(bus.penable), 32'h1);
                chk("en_psel", 32'(bus.psel), 32'(sel_of(cur[95:64])));
                chk("en_paddr", bus.paddr, cur[95:64]);
                chk("en_pwrite", 32'(bus.pwrite), 32'(cur[96]));
                in_setup = 1'b0;
                if (cur[96]) begin
                    chk("en_pwdata", bus.pwdata, cur[63:32]);
                end else begin
                    bus.prdata = cur[31:0];
                    #1;
                    chk("hr_data", bus.hr_data, cur[31:0]);
                end
            end else if ((bus.psel != 3'b000) || bus.penable) begin
                chk("setup_penable", 32'(bus.penable), 32'h0);
                if (exp_q.size() == 0) begin
                    chk("spurious_psel", 32'(bus.psel), 32'h0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("su_psel", 32'(bus.psel), 32'(sel_of(cur[95:64])));
                    chk("su_paddr", bus.paddr, cur[95:64]);
                    chk("su_pwrite", 32'(bus.pwrite), 32'(cur[96]));
                    if (cur[96]) chk("su_pwdata", bus.pwdata, cur[63:32]);
                    in_setup = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One AHB burst; called and returns at posedge+1. Beats advance only when ready was high.
    task automatic do_burst(input logic wr, input logic [31:0] base, input int len,
                            input logic [31:0] wd0, input logic [31:0] rd0, input bit fixed);
        int          k;
        int          stalls;
        logic        rdy;
        logic [31:0] wd;
        logic [31:0] rd;
        k = 0;
        stalls = 0;
        while (k < len) begin
            bus.haddr  = base + 32'(4 * k);
            bus.htrans = (k == 0) ? 2'b10 : 2'b11;
            bus.hwrite = wr;
            @(negedge hclk);
            rdy = bus.hr_readyout;
            @(posedge hclk);
            #1;
            if (rdy) begin
                wd = fixed ? wd0 + 32'(k) : $urandom;
                rd = fixed ? rd0 + 32'(k) : $urandom;
                exp_q.push_back({wr, bus.haddr, wd, rd});
                if (wr) bus.hwdata = wd;
                k++;
                stalls = 0;
            end else begin
                stalls++;
                if (stalls > 8) begin
                    chk("accept_timeout", 32'(stalls), 32'h0);
                    break;
                end
            end
        end
        // Idle with address/direction/data held while the last transfer drains
        bus.htrans = 2'b00;
        repeat (5) @(posedge hclk);
        #1;
    endtask

    // Cycles that must not start any APB transfer
    task automatic noise(input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                bus.htrans = 2'($urandom_range(0, 1));
            end else begin
                if (a >= 32'h8000_0000 && a < 32'h8C00_0000) a = a ^ 32'h4000_0000;
                bus.htrans = 2'($urandom_range(2, 3));
            end
            bus.haddr  = a;
            bus.hwrite = 1'($urandom_range(0, 1));
            bus.hwdata = $urandom;
            @(posedge hclk);
            #1;
        end
        bus.htrans = 2'b00;
    endtask

    task automatic rand_base(output logic [31:0] b);
        b = 32'h8000_0000 + 32'($urandom_range(0, 2)) * 32'h0400_0000
            + (32'($urandom_range(0, 32'h00FF_FFC0)) & 32'hFFFF_FFFC);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] b;
        bus.hwrite = 1'b0;
        bus.htrans = 2'b00;
        bus.haddr  = '0;
        bus.hwdata = '0;
        hresetn    = 1'b1;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_psel", 32'(bus.psel), 32'h0);
        chk("rst_penable", 32'(bus.penable), 32'h0);
        chk("rst_readyout", 32'(bus.hr_readyout), 32'h1);
        chk("rst_hresp", 32'(bus.hresp), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'h0);
        chk("rst_paddr", bus.paddr, 32'h0);
        hresetn = 1'b0;

        // Directed cases
        do_burst(1'b1, 32'h8000_0000, 1, 32'h0000_00A5, 32'h0, 1'b1);
        do_burst(1'b0, 32'h8400_0010, 1, 32'h0, 32'h1234_5678, 1'b1);
        do_burst(1'b0, 32'h8800_0000, 4, 32'h0, $urandom, 1'b0);
        do_burst(1'b1, 32'h8000_0000, 4, 32'h0000_0001, 32'h0, 1'b1);

        bus.haddr = 32'h9000_0000; bus.htrans = 2'b10; bus.hwrite = 1'b0;
        @(posedge hclk); #1;
        bus.haddr = 32'h8000_0000; bus.htrans = 2'b01; bus.hwrite = 1'b1;
        @(posedge hclk); #1;
        bus.htrans = 2'b00;
        noise(6);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            rand_base(b);
            do_burst(1'($urandom_range(0, 1)), b, $urandom_range(1, 4), 32'h0, 32'h0, 1'b0);
            if ($urandom_range(0, 2) == 0) noise($urandom_range(1, 4));
        end

        // Reset during an enable cycle drops the transfer
        bus.haddr = 32'h8800_0020; bus.hwrite = 1'b1; bus.htrans = 2'b10;
        @(posedge hclk); #1;
        exp_q.push_back({1'b1, 32'h8800_0020, 32'hCAFE_F00D, 32'h0});
        bus.hwdata = 32'hCAFE_F00D;
        bus.htrans = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge hclk);
            if (bus.penable) break;
        end
        chk("enable_seen", 32'(bus.penable), 32'h1);
        #2 hresetn = 1'b1;
        @(posedge hclk); #1;
        chk("midrst_penable", 32'(bus.penable), 32'h0);
        chk("midrst_psel", 32'(bus.psel), 32'h0);
        chk("midrst_readyout", 32'(bus.hr_readyout), 32'h1);
        chk("midrst_paddr", bus.paddr, 32'h0);
        chk("midrst_pwdata", bus.pwdata, 32'h0);
        chk("midrst_state", 32'(dbg_state), 32'h0);
        @(posedge hclk); #1;
        hresetn = 1'b0;

        // Recovery after reset
        do_burst(1'b0, 32'h8000_0100, 2, 32'h0, 32'h0, 1'b0);
        do_burst(1'b1, 32'h8400_0200, 3, 32'h0, 32'h0, 1'b0);

        repeat (10) @(posedge hclk);
        #1;
        chk("exp_q_left", 32'(exp_q.size()), 32'h0);
        chk("end_state", 32'(dbg_state), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge_core.md
Name: ahb_apb_bridge_core

Overview:
- Single-clock AHB-to-APB bridge core: one AHB slave on the input side, one APB master on the output side.
- Front end: AHB slave-interface logic. Pipelines the address, write data and direction, decodes the slave select, and generates the transfer-valid qualifier.
- Back end: APB controller FSM. Turns each valid AHB transfer into an APB setup phase followed by an enable phase, and stalls the AHB side with hr_readyout.
- In system use, an AHB master drives the inputs and an APB slave returns prdata.

Parameters:
- none (address map and widths fixed below)

Ports:
- hclk  in  1  rising-edge clock
- hresetn  in  1  synchronous active-high reset: 1 = reset, sampled on hclk rising edge; name kept per codebase
- hwrite  in  1  AHB direction, 1 = write
- hready_in  in  1  AHB ready into the slave
- htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hwdata  in  32  AHB write data
- haddr  in  32  AHB address
- prdata  in  32  APB read data
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- hr_readyout  out  1  AHB ready out; 0 stalls the master
- psel  out  3  one-hot APB slave select
- hresp  out  2  AHB response
- paddr  out  32  APB address
- pwdata  out  32  APB write data
- hr_data  out  32  AHB read data

Behaviour:
- Pipeline registers, updated every hclk while not in reset, all cleared by reset:
  - haddr1 <= haddr, haddr2 <= haddr1
  - hwdata1 <= hwdata, hwdata2 <= hwdata1
  - hwrite_reg <= hwrite, hwrite_reg1 <= hwrite_reg
- valid (combinational) = hready_in AND htrans in {10, 11} AND 0x8000_0000 <= haddr < 0x8C00_0000.
- temp_sel (combinational decode of haddr):
  - [0x8000_0000, 0x8400_0000) -> 001
  - [0x8400_0000, 0x8800_0000) -> 010
  - [0x8800_0000, 0x8C00_0000) -> 100
  - any other address -> 000
- hresp = 00 constantly. hr_data = prdata, combinational pass-through.
- FSM states: ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP.
- State transitions:
  - IDLE: valid&hwrite -> WWAIT; valid&!hwrite -> READ; else stay in IDLE.
  - WWAIT: valid -> WRITEP; else -> WRITE.
  - READ -> RENABLE, unconditional.
  - WRITE: valid -> WENABLEP; else -> WENABLE.
  - WRITEP -> WENABLEP, unconditional.
  - RENABLE, WENABLE: valid&!hwrite -> READ; valid&hwrite -> WWAIT; else -> IDLE.
  - WENABLEP: !hwrite_reg -> READ; hwrite_reg&valid -> WRITEP; hwrite_reg&!valid -> WRITE.
- All APB outputs and hr_readyout are registered. Values loaded at the edge that leaves each state:
  - IDLE/RENABLE/WENABLE -> READ: paddr=haddr, pwrite=0, psel=temp_sel, penable=0, hr_readyout=0.
  - IDLE/RENABLE/WENABLE -> WWAIT or IDLE: psel=000, penable=0, hr_readyout=1.
  - READ -> RENABLE: penable=1, hr_readyout=1.
  - WWAIT -> WRITE/WRITEP: paddr=haddr1, pwdata=hwdata, pwrite=1, psel=temp_sel, penable=0, hr_readyout=0.
  - WRITE/WRITEP -> WENABLE/WENABLEP: penable=1, hr_readyout=1.
  - WENABLEP -> any state: paddr=haddr2, pwdata=hwdata, pwrite=hwrite, psel=temp_sel, penable=0, hr_readyout=0.
- APB protocol: every APB transfer is exactly one setup cycle (psel!=0, penable=0) then one enable cycle (penable=1). prdata is sampled by the AHB master in the enable cycle through hr_data.
- Read latency: NONSEQ read accepted in IDLE -> setup on the next cycle, enable the cycle after. hr_readyout is low for 1 cycle per read.
- Write: the address phase is held one cycle (WWAIT) so hwdata is available; the write setup then uses the delayed address haddr1.
- Reset (any cycle, including mid-transfer), next edge:
  - state = IDLE; penable=0, pwrite=0, psel=000, paddr=0, pwdata=0, hr_readyout=1.
  - Any in-progress transfer is dropped.
- Out-of-range address or htrans IDLE/BUSY: valid=0, no APB activity, hr_readyout stays 1.

Test Plan:
- Reset held 2 cycles -> psel=000, penable=0, hr_readyout=1, hresp=00, state IDLE.
- Single write, haddr=0x8000_0000, NONSEQ, hwdata=0x0000_00A5 next cycle -> one setup (psel=001, pwrite=1, paddr=0x8000_0000, pwdata=0xA5, penable=0), then enable (penable=1); then IDLE.
- Single read, haddr=0x8400_0010, prdata=0x1234_5678 -> psel=010, pwrite=0, paddr=0x8400_0010, penable 0 then 1; hr_data=0x1234_5678; hr_readyout low exactly 1 cycle.
- INCR4 read at 0x8800_0000 (NONSEQ + 3 SEQ, +4 each) -> four APB reads, paddr 0x8800_0000/04/08/0C, psel=100, alternating READ/RENABLE.
- INCR4 write at 0x8000_0000, data 1..4 -> four APB writes, paddr in order, pwdata 1..4, pipelined through WRITEP/WENABLEP.
- haddr=0x9000_0000 or htrans=01 -> no psel assertion, hr_readyout=1; reset asserted during an enable cycle -> next edge penable=0, psel=000.
